bp_sink: RTL and testbench
==========================

# bp_sink

Receive-side endpoint for the backpressured BFT network: accepts packets from the router leaf port, buffers them in a show-ahead FIFO, throttles the network with `c_i_bp`, and checks each popped packet's address and packet ID. Packet IDs are `src*LIMIT + seq`. The block sits at a PE leaf opposite the traffic injector. It reports received count, sticky error flags and a `done` flag for the testbench or a system controller.

## Interface
- `N`, 2: number of clients.
- `D_W`, 32: data width; carries the packet ID.
- `A_W`, `$clog2(N)+1`: address field width.
- `LIMIT`, 16: packets per source; power of two.
- `EXPECT`, 16: total packets this sink must receive before `done`.
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `posx`, 0: this PE's address.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ce` in 1: enables pop and checker; push is never gated.
- `c_i` in A_W+D_W+1: packet. Bit A_W+D_W is reserved and ignored. [A_W+D_W-1:D_W] is the destination. [D_W-1:0] is the packet ID.
- `c_i_v` in 1: packet valid.
- `c_i_bp` out 1: registered backpressure to the router.
- `p_o` out D_W: head packet ID.
- `p_o_src` out A_W: head source, `p_o >> log2(LIMIT)`.
- `p_o_v` out 1: FIFO not empty.
- `p_o_rdy` in 1: consumer ready.
- `rx_count` out 32: packets popped.
- `err` out 4: sticky flags {order, src, addr, overflow}.
- `done` out 1: registered completion flag.

## Operation
- Storage: each entry holds `c_i[A_W+D_W-1:0]`.
- Read/write pointers are `$clog2(DEPTH)+1` bits wide. They wrap naturally. Full when MSBs differ and the remaining bits are equal.
- Push: at a clock edge when `c_i_v` is high and the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Overflow: if `c_i_v` is high, the FIFO is full and there is no pop, the packet is dropped and `err[0]` is set.
- Pop: when `p_o_v & p_o_rdy & ce`. Push and pop in the same cycle leave the count unchanged.
- `count_next` is the occupancy after this edge's push and pop.
- Backpressure: `c_i_bp <= (count_next >= DEPTH-1)`. One slot of skid is reserved for a packet already in flight when bp rises.
- Checker, evaluated on each pop:
  - Destination field ≠ `posx`: set `err[1]`.
  - `p_o_src >= N`: set `err[2]`.
  - `seq = p_o & (LIMIT-1)`.
- `rx_count` increments on every pop and saturates at 2^32-1.
- Errors are sticky and clear only on reset.
- `done <= (rx_count == EXPECT) & ~p_o_v & ~c_i_v`. The comparison uses the pre-edge `rx_count`. `done` deasserts if a later packet arrives.
- Mid-operation reset: FIFO contents are discarded, pointers are zeroed, and all outputs return to their reset values on the next edge.

## Timing
- Reset values:
  - `c_i_bp`=0, `p_o_v`=0, `rx_count`=0, `err`=0, `done`=0.
  - `p_o` and `p_o_src` are don't-care while `p_o_v`=0.
- Latency: a packet pushed at edge k is visible on `p_o`/`p_o_v` after edge k, with 1-cycle minimum.
- `p_o`, `p_o_src` and `p_o_v` are combinational from the head entry and pointers.
- `c_i_bp` reflects occupancy with one cycle of delay. The upstream side stops the cycle after it sees `c_i_bp`=1.
- `rx_count` and `err` update at the pop edge. `done` follows one cycle later.
- With `ce`=0, the FIFO keeps filling and `c_i_bp` still protects it; `rx_count` and `err` hold.

## Configuration
- `BP_SINK_ORDER_CHECK_EN` defined:
  - The block keeps a per-source expected-sequence array: N entries, `$clog2(LIMIT)` bits each, reset to 0.
  - On each pop with a valid source, if `seq` ≠ expected for that source, `err[3]` is set.
  - Expected for that source is then loaded with `seq+1`, wrapping modulo LIMIT.
- `BP_SINK_ORDER_CHECK_EN` not defined: no array is built and `err[3]` is tied to 0.

## Test plan
- Reset, then one packet (dest=posx, ID=LIMIT*1+0) with `p_o_rdy`=1 → `p_o_v` high for 1 cycle, `p_o_src`=1, `rx_count`=1, `err`=0.
- `p_o_rdy`=0, stream 8 packets (DEPTH=8) while honouring bp → `c_i_bp` rises the cycle after count reaches 7, all 8 stored, `err[0]`=0. Then release `p_o_rdy` → 8 pops in order.
- Full FIFO, no pop, force `c_i_v` for 1 cycle → packet dropped, `err[0]`=1. Simultaneous push+pop at full → accepted, count stays 8.
- Packet with dest ≠ posx → `err[1]`=1. Packet with ID=N*LIMIT → `err[2]`=1.
- Order check enabled: source 1 sends seq 0, 2 → `err[3]`=1 on second pop. Macro undefined → `err[3]`=0.
- EXPECT=16: 16 packets delivered and drained → `done`=1 one cycle after the last pop. A 17th arrival drops `done` to 0. Assert `rst` mid-stream → all outputs reset next edge.

Source files
------------

// File: rtl/bp_sink.sv
// rtl/bp_sink.sv - BFT leaf receive endpoint: show-ahead FIFO, registered backpressure, packet checker
//
// Optional feature: define BP_SINK_ORDER_CHECK_EN to build the per-source
// sequence tracker that drives err[3]; without it err[3] is tied to 0.
//
// Packet layout on c_i: [A_W+D_W] reserved, [A_W+D_W-1:D_W] destination,
// [D_W-1:0] packet ID = src*LIMIT + seq.

module bp_sink #(
  parameter int N      = 2,
  parameter int D_W    = 32,
  parameter int A_W    = $clog2(N) + 1,
  parameter int LIMIT  = 16,
  parameter int EXPECT = 16,
  parameter int DEPTH  = 8,
  parameter int posx   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [A_W+D_W:0] c_i,
  input  logic             c_i_v,
  output logic             c_i_bp,
  output logic [D_W-1:0]   p_o,
  output logic [A_W-1:0]   p_o_src,
  output logic             p_o_v,
  input  logic             p_o_rdy,
  output logic [31:0]      rx_count,
  output logic [3:0]       err,
  output logic             done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LG  = $clog2(LIMIT);
  localparam int E_W = A_W + D_W;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;

  // Backpressure threshold leaves exactly one free slot for the packet that
  // is already on the wire when c_i_bp rises.
  localparam logic [PW-1:0] BP_LEVEL = PW'(DEPTH - 1);

  logic [E_W-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  count;
  logic [PW-1:0]  count_next;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           overflow;

  logic [E_W-1:0] head;
  logic [A_W-1:0] head_dest;
  logic [D_W-1:0] src_full;
  logic [SW-1:0]  src_idx;
  logic [LG-1:0]  seq;
  logic           src_ok;
  logic           addr_err;
  logic           src_err;
  logic           order_err;

  // Pointer-derived FIFO status; pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate counter.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    count      = wr_ptr - rd_ptr;
    pop        = ~empty & p_o_rdy & ce;
    // A full FIFO can still accept when the head leaves on the same edge.
    push       = c_i_v & (~full | pop);
    overflow   = c_i_v & full & ~pop;
    count_next = count + PW'(push) - PW'(pop);
  end

  // Show-ahead head decode: outputs are combinational from the head entry.
  always_comb begin
    head      = mem[rd_ptr[AW-1:0]];
    head_dest = head[E_W-1:D_W];
    p_o       = head[D_W-1:0];
    p_o_v     = ~empty;
    src_full  = p_o >> LG;
    p_o_src   = src_full[A_W-1:0];
    src_idx   = src_full[SW-1:0];
    seq       = p_o[LG-1:0];
    // Source is judged on the full-width shift so out-of-range IDs are not
    // hidden by truncation to the address width.
    src_ok    = (src_full < D_W'(N));
    addr_err  = pop & (head_dest != A_W'(posx));
    src_err   = pop & ~src_ok;
  end

  // Entry storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= c_i[E_W-1:0];
    end
  end

  // Pointer advance; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered backpressure from post-edge occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_i_bp <= 1'b0;
    end else begin
      c_i_bp <= (count_next >= BP_LEVEL);
    end
  end

`ifdef BP_SINK_ORDER_CHECK_EN
  logic [LG-1:0] exp_seq [N];

  always_comb begin
    order_err = pop & src_ok & (seq != exp_seq[src_idx]);
  end

  // Per-source expected sequence, resynchronised to the observed seq so one
  // gap flags once rather than on every following packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        exp_seq[i] <= '0;
      end
    end else if (pop && src_ok) begin
      exp_seq[src_idx] <= seq + 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = c_i[E_W];
`else
  assign order_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{c_i[E_W], src_idx, seq};
`endif

  // Sticky error flags {order, src, addr, overflow}; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= '0;
    end else begin
      err <= err | {order_err, src_err, addr_err, overflow};
    end
  end

  // Saturating count of popped packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count <= '0;
    end else if (pop && (rx_count != 32'hFFFF_FFFF)) begin
      rx_count <= rx_count + 32'd1;
    end
  end

  // Completion: expected total seen, FIFO drained, nothing arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (rx_count == 32'(EXPECT)) & ~p_o_v & ~c_i_v;
    end
  end

endmodule

// File: tb/tb_bp_sink.sv
// tb/tb_bp_sink.sv - directed self-checking bench for bp_sink

module tb_bp_sink;

  localparam int N     = 2;
  localparam int D_W   = 32;
  localparam int A_W   = $clog2(N) + 1;
  localparam int LIMIT = 16;

`ifdef BP_SINK_ORDER_CHECK_EN
  localparam logic [3:0] ORDER_FLAG = 4'b1000;
`else
  localparam logic [3:0] ORDER_FLAG = 4'b0000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic [A_W+D_W:0] c_i;
  logic             c_i_v;
  logic             c_i_bp;
  logic [D_W-1:0]   p_o;
  logic [A_W-1:0]   p_o_src;
  logic             p_o_v;
  logic             p_o_rdy;
  logic [31:0]      rx_count;
  logic [3:0]       err;
  logic             done;

  int errors = 0;
  int checks = 0;

  bp_sink #(
    .N(N), .D_W(D_W), .A_W(A_W), .LIMIT(LIMIT), .EXPECT(16), .DEPTH(8), .posx(0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .c_i(c_i), .c_i_v(c_i_v), .c_i_bp(c_i_bp),
    .p_o(p_o), .p_o_src(p_o_src), .p_o_v(p_o_v), .p_o_rdy(p_o_rdy),
    .rx_count(rx_count), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [A_W+D_W:0] pkt(input logic [A_W-1:0] dest, input logic [D_W-1:0] id);
    return {1'b0, dest, id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [A_W-1:0] dest, input logic [D_W-1:0] id);
    c_i_v = 1'b1;
    c_i   = pkt(dest, id);
    step();
    c_i_v = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; c_i = '0; c_i_v = 1'b0; p_o_rdy = 1'b0;
    step();
    step();
    check("rst_bp",   64'(c_i_bp),   64'(0));
    check("rst_pov",  64'(p_o_v),    64'(0));
    check("rst_rx",   64'(rx_count), 64'(0));
    check("rst_err",  64'(err),      64'(0));
    check("rst_done", 64'(done),     64'(0));
    rst = 1'b0;

    // single packet from source 1, seq 0
    p_o_rdy = 1'b1;
    c_i_v = 1'b1; c_i = pkt(0, 16);
    step();
    c_i_v = 1'b0;
    check("one_pov", 64'(p_o_v),   64'(1));
    check("one_src", 64'(p_o_src), 64'(1));
    check("one_id",  64'(p_o),     64'(16));
    step();
    check("one_pov_gone", 64'(p_o_v),    64'(0));
    check("one_rx",       64'(rx_count), 64'(1));
    check("one_err",      64'(err),      64'(0));
    check("one_done",     64'(done),     64'(0));

    // fill with 8 packets, bp rises after the 7th
    p_o_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c_i_v = 1'b1; c_i = pkt(0, 32'(i));
      step();
      check($sformatf("fill_bp%0d", i), 64'(c_i_bp), 64'(i >= 6 ? 1 : 0));
    end
    c_i_v = 1'b0;
    check("fill_err",  64'(err),   64'(0));
    check("fill_pov",  64'(p_o_v), 64'(1));
    check("fill_head", 64'(p_o),   64'(0));

    // overflow while full and not popping
    c_i_v = 1'b1; c_i = pkt(0, 99);
    step();
    c_i_v = 1'b0;
    check("ovf_err",  64'(err), 64'(4'b0001));
    check("ovf_head", 64'(p_o), 64'(0));

    // push and pop together at full
    p_o_rdy = 1'b1;
    c_i_v = 1'b1; c_i = pkt(0, 8);
    step();
    c_i_v = 1'b0;
    check("pp_bp",   64'(c_i_bp),   64'(1));
    check("pp_head", 64'(p_o),      64'(1));
    check("pp_rx",   64'(rx_count), 64'(2));
    check("pp_err",  64'(err),      64'(4'b0001));

    // drain: exactly eight more in order
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_id%0d", i), 64'(p_o), 64'(i));
      step();
    end
    check("drain_pov", 64'(p_o_v),    64'(0));
    check("drain_rx",  64'(rx_count), 64'(10));
    check("drain_bp",  64'(c_i_bp),   64'(0));

    // wrong destination, then out-of-range source
    send(1, 9);
    check("addr_err", 64'(err),      64'(4'b0011));
    check("addr_rx",  64'(rx_count), 64'(11));
    send(0, 32'(N * LIMIT));
    check("src_err", 64'(err),      64'(4'b0111));
    check("src_rx",  64'(rx_count), 64'(12));

    // source 1: seq 1 follows seq 0, then seq 3 skips
    send(0, 17);
    check("ord_ok",  64'(err), 64'(4'b0111));
    send(0, 19);
    check("ord_gap", 64'(err), 64'(4'b0111 | ORDER_FLAG));
    check("ord_rx",  64'(rx_count), 64'(14));

    // reach EXPECT and drain
    send(0, 20);
    check("pre_done_rx", 64'(rx_count), 64'(15));
    c_i_v = 1'b1; c_i = pkt(0, 21);
    step();
    c_i_v = 1'b0;
    step();
    check("last_pop_rx",   64'(rx_count), 64'(16));
    check("last_pop_done", 64'(done),     64'(0));
    step();
    check("done_high", 64'(done), 64'(1));

    // 17th arrival drops done
    p_o_rdy = 1'b0;
    c_i_v = 1'b1; c_i = pkt(0, 22);
    step();
    check("late_done", 64'(done),     64'(0));
    check("late_pov",  64'(p_o_v),    64'(1));
    check("late_rx",   64'(rx_count), 64'(16));

    // reset mid-stream with a packet on the wire
    rst = 1'b1; c_i = pkt(0, 23);
    step();
    check("mrst_bp",   64'(c_i_bp),   64'(0));
    check("mrst_pov",  64'(p_o_v),    64'(0));
    check("mrst_rx",   64'(rx_count), 64'(0));
    check("mrst_err",  64'(err),      64'(0));
    check("mrst_done", 64'(done),     64'(0));
    rst = 1'b0; c_i_v = 1'b0;
    step();
    check("post_rst_pov", 64'(p_o_v), 64'(0));
    check("post_rst_err", 64'(err),   64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
